// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

  localparam logic       ReqInst  = 1'b0;
  localparam logic       ReqData  = 1'b1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef enum logic [1:0] {
    LockNone = 2'd0,
    LockInst = 2'd1,
    LockData = 2'd2
  } lock_e;

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit requester tags for accepted-but-unanswered transactions.
module mem_req_arbiter_tag_fifo #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push_i,
  input  logic            tag_i,
  input  logic            pop_i,
  output logic            tag_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign tag_o   = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= tag_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, with in-order
// response steering, fetch starvation protection and a fetch-blocked cycle counter.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned Outstanding = 4,
  parameter int unsigned StarveLimit = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,

  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,

  output logic [31:0] rdata_o,

  output logic        m_req_o,
  output logic        m_wr_o,
  output logic [1:0]  m_size_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_addr_ok_i,
  input  logic        m_data_ok_i,
  input  logic [31:0] m_rdata_i,

  output logic        proto_err_o,
  output logic [31:0] perfcnt_inst_blocked_o
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);
  localparam int unsigned CntW    = $clog2(Outstanding) + 1;

  lock_e               lock_q, lock_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [31:0]         perf_q, perf_d;
  logic                proto_q, proto_d;

  logic                gnt_inst;
  logic                gnt_data;
  logic                accept;
  logic                pop;
  logic                head_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CntW-1:0]     fifo_count;

  // Grant is combinational; an existing lock overrides the priority decision.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    unique case (lock_q)
      LockInst: gnt_inst = inst_req_i;
      LockData: gnt_data = data_req_i;
      default: begin
        if (inst_req_i && (starve_q == StarveW'(StarveLimit))) begin
          gnt_inst = 1'b1;
        end else if (data_req_i) begin
          gnt_data = 1'b1;
        end else if (inst_req_i) begin
          gnt_inst = 1'b1;
        end
      end
    endcase
  end

  assign m_req_o   = resetn && (gnt_inst || gnt_data) && !fifo_full;
  assign m_wr_o    = gnt_data && data_wr_i;
  assign m_size_o  = gnt_inst ? SizeWord : data_size_i;
  assign m_addr_o  = gnt_inst ? inst_addr_i : data_addr_i;
  assign m_wdata_o = gnt_data ? data_wdata_i : '0;

  assign accept         = m_req_o && m_addr_ok_i;
  assign inst_addr_ok_o = accept && gnt_inst;
  assign data_addr_ok_o = accept && gnt_data;

  assign fifo_empty     = (fifo_count == '0);
  assign pop            = resetn && m_data_ok_i && !fifo_empty;
  assign inst_data_ok_o = pop && (head_tag == ReqInst);
  assign data_data_ok_o = pop && (head_tag == ReqData);
  assign rdata_o        = m_rdata_i;

  mem_req_arbiter_tag_fifo #(
    .Depth (Outstanding)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .tag_i   (gnt_data ? ReqData : ReqInst),
    .pop_i   (pop),
    .tag_o   (head_tag),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_comb begin
    if (accept) begin
      lock_d = LockNone;
    end else if (gnt_inst) begin
      lock_d = LockInst;
    end else if (gnt_data) begin
      lock_d = LockData;
    end else begin
      lock_d = LockNone;
    end

    starve_d = starve_q;
    if (!inst_req_i || inst_addr_ok_o) begin
      starve_d = '0;
    end else if (data_addr_ok_o && (starve_q != StarveW'(StarveLimit))) begin
      starve_d = starve_q + 1'b1;
    end

    perf_d  = perf_q + 32'(inst_req_i && !(gnt_inst && m_req_o));
    proto_d = proto_q || (m_data_ok_i && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q   <= LockNone;
      starve_q <= '0;
      perf_q   <= '0;
      proto_q  <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      starve_q <= starve_d;
      perf_q   <= perf_d;
      proto_q  <= proto_d;
    end
  end

  assign proto_err_o            = proto_q;
  assign perfcnt_inst_blocked_o = perf_q;

endmodule
